// File: rtl/sdcard_cmd_engine.sv
// sdcard_cmd_engine
//
// Drives the SD CMD line for one command/response exchange. A command
// (index, argument, response type) is framed with a CRC7 and shifted out
// MSB first, one bit per SD clock tick. The engine then releases the line,
// waits for the card's start bit (bounded by a tick timeout), shifts in a
// 48-bit or 136-bit response and checks end/transmission bits, index and CRC.
//
// Ports:
//   PCLK_i, PRESET_i         system clock, synchronous active-high reset
//   sdclk_tick_i             one-PCLK strobe per SD clock period
//   cmd_start_i              start request (honoured only when idle)
//   cmd_index_i, cmd_arg_i   command index and argument
//   rsp_type_i               00 none, 01 short+checks, 10 long, 11 short unchecked
//   timeout_i                ticks to wait for the response start bit
//   cmd_out_o, cmd_oe_o      CMD pad drive value and output enable
//   cmd_in_i                 CMD pad sampled value
//   busy_o, done_o           engine active / one-cycle completion pulse
//   rsp_o, rsp_index_o       response payload and received index
//   err_*_o                  sticky error flags, cleared on acceptance

module sdcard_cmd_engine (
    input  logic         PCLK_i,
    input  logic         PRESET_i,
    input  logic         sdclk_tick_i,
    input  logic         cmd_start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   rsp_type_i,
    input  logic [15:0]  timeout_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    input  logic         cmd_in_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] rsp_o,
    output logic [5:0]   rsp_index_o,
    output logic         err_timeout_o,
    output logic         err_crc_o,
    output logic         err_end_o,
    output logic         err_index_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [47:0]   tx_shift;
    logic [127:0]  rx_shift;
    logic          trans_bit;
    logic [7:0]    bit_cnt;
    logic [15:0]   wait_cnt;
    logic [5:0]    lat_index;
    logic [1:0]    lat_type;
    logic [15:0]   lat_timeout;

    logic [15:0]   wait_limit;
    logic [15:0]   wait_inc;
    logic          is_long;
    logic          tx_end;
    logic          rx_last;
    logic          end_bad;
    logic          index_bad;
    logic          crc_bad;

    // CRC7, polynomial x^7 + x^3 + 1, register starts at zero, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    assign wait_limit = (lat_timeout == 16'd0) ? 16'd1 : lat_timeout;
    assign wait_inc   = wait_cnt + 16'd1;
    assign is_long    = (lat_type == 2'b10);
    // bit_cnt reaches 48 after the end bit has been put on the line; the
    // following tick is the one that releases the line.
    assign tx_end     = (bit_cnt == 8'd48);
    assign rx_last    = ((bit_cnt + 8'd1) == (is_long ? 8'd136 : 8'd48));

    // The transmission bit is the first bit after the start bit for both
    // response lengths, so it is captured separately and the shift register
    // only needs to hold the 128 payload bits of a long response.
    assign end_bad    = trans_bit | ~rx_shift[0];
    assign index_bad  = (rx_shift[45:40] != lat_index);
    assign crc_bad    = (crc7(rx_shift[47:8]) != rx_shift[7:1]);

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (cmd_start_i) begin
                    state_next = S_TX;
                end
            end
            S_TX: begin
                if (sdclk_tick_i && tx_end) begin
                    state_next = (lat_type == 2'b00) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (sdclk_tick_i) begin
                    if (!cmd_in_i) begin
                        state_next = S_RX;
                    end else if (wait_inc == wait_limit) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_RX: begin
                if (sdclk_tick_i && rx_last) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                busy_o     = 1'b0;
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Shift registers carry no reset: their contents are only consumed after
    // a full frame has been loaded or shifted in.
    always_ff @(posedge PCLK_i) begin
        if (state == S_IDLE && cmd_start_i) begin
            tx_shift <= {2'b01, cmd_index_i, cmd_arg_i,
                         crc7({2'b01, cmd_index_i, cmd_arg_i}), 1'b1};
        end else if (state == S_TX && sdclk_tick_i && !tx_end) begin
            tx_shift <= {tx_shift[46:0], 1'b0};
        end
        if ((state == S_WAIT || state == S_RX) && sdclk_tick_i) begin
            rx_shift <= {rx_shift[126:0], cmd_in_i};
        end
        if (state == S_RX && sdclk_tick_i && bit_cnt == 8'd1) begin
            trans_bit <= cmd_in_i;
        end
    end

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            cmd_out_o     <= 1'b1;
            cmd_oe_o      <= 1'b0;
            bit_cnt       <= 8'd0;
            wait_cnt      <= 16'd0;
            lat_index     <= 6'd0;
            lat_type      <= 2'b00;
            lat_timeout   <= 16'd0;
            rsp_o         <= 128'd0;
            rsp_index_o   <= 6'd0;
            err_timeout_o <= 1'b0;
            err_crc_o     <= 1'b0;
            err_end_o     <= 1'b0;
            err_index_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_start_i) begin
                        cmd_oe_o      <= 1'b1;
                        cmd_out_o     <= 1'b1;
                        bit_cnt       <= 8'd0;
                        lat_index     <= cmd_index_i;
                        lat_type      <= rsp_type_i;
                        lat_timeout   <= timeout_i;
                        rsp_o         <= 128'd0;
                        rsp_index_o   <= 6'd0;
                        err_timeout_o <= 1'b0;
                        err_crc_o     <= 1'b0;
                        err_end_o     <= 1'b0;
                        err_index_o   <= 1'b0;
                    end
                end
                S_TX: begin
                    if (sdclk_tick_i) begin
                        if (!tx_end) begin
                            cmd_out_o <= tx_shift[47];
                            bit_cnt   <= bit_cnt + 8'd1;
                        end else begin
                            // End bit has been held a full tick; release.
                            cmd_oe_o  <= 1'b0;
                            cmd_out_o <= 1'b1;
                            wait_cnt  <= 16'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (sdclk_tick_i) begin
                        if (!cmd_in_i) begin
                            bit_cnt <= 8'd1;
                        end else begin
                            wait_cnt <= wait_inc;
                            if (wait_inc == wait_limit) begin
                                err_timeout_o <= 1'b1;
                            end
                        end
                    end
                end
                S_RX: begin
                    if (sdclk_tick_i) begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (end_bad) begin
                        err_end_o <= 1'b1;
                    end
                    if (lat_type == 2'b01) begin
                        err_index_o <= index_bad;
                        err_crc_o   <= crc_bad;
                    end
                    if (is_long) begin
                        rsp_o       <= {rx_shift[127:1], 1'b0};
                        rsp_index_o <= 6'd0;
                    end else begin
                        rsp_o       <= {96'd0, rx_shift[39:8]};
                        rsp_index_o <= rx_shift[45:40];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/sdcard_cmd_engine.md
# sdcard_cmd_engine

Command-line engine of the SD card controller: takes a command (index, argument, response type) from the controller's register/sequencer logic and serialises the 48-bit frame onto the SD CMD line with a generated CRC7. It then waits for and deserialises the card's 48- or 136-bit response and performs timeout, CRC, index and end-bit checks. It sits directly between the controller core and the `sdcard_cmd_io` pad; the tristate is split into `oe`/`out`/`in` at this boundary.

## Interface
- No parameters; widths are fixed by the SD physical layer.
- `PCLK_i` in 1: system clock; all logic on its rising edge.
- `PRESET_i` in 1: reset, synchronous, active-high.
- `sdclk_tick_i` in 1: one-PCLK strobe, once per SD clock period. All bit-level activity advances only on ticks.
- `cmd_start_i` in 1: start request. Sampled only in IDLE.
- `cmd_index_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `rsp_type_i` in 2: response type.
  - 00: none.
  - 01: short, with CRC and index check (R1/R6/R7).
  - 10: long, 136 bits (R2).
  - 11: short, no CRC/index check (R3).
- `timeout_i` in 16: maximum number of ticks to wait for the response start bit.
- `cmd_out_o` out 1: CMD line drive value.
- `cmd_oe_o` out 1: CMD line output enable.
- `cmd_in_i` in 1: CMD line sampled value.
- `busy_o` out 1: engine not in IDLE.
- `done_o` out 1: one-PCLK completion pulse.
- `rsp_o` out 128: response payload.
  - Short: `[31:0]` = card bits 39:8; upper bits are 0.
  - Long: `[127:1]` = card bits 127:1; `[0]` = 0.
- `rsp_index_o` out 6: received index field (short responses only).
- `err_timeout_o`, `err_crc_o`, `err_end_o`, `err_index_o` out 1 each: sticky error flags.

## Operation
- Frame transmitted MSB first: `{1'b0, 1'b1, cmd_index_i, cmd_arg_i, crc7, 1'b1}`.
  - crc7 uses polynomial x^7+x^3+1, register initialised to 0, computed over the first 40 bits.
- States:
  - **IDLE**
    - `cmd_start_i`=1 → latch inputs, clear `rsp_o`/`rsp_index_o`/all error flags → TX.
  - **TX**
    - Ticks 1..48 each present the next frame bit on `cmd_out_o`.
    - Tick 49 drops `cmd_oe_o`, forces `cmd_out_o`=1, clears the wait counter.
    - Next state: DONE if type 00, else WAIT.
  - **WAIT**
    - Each tick samples `cmd_in_i`.
    - 0 → start bit received, bit count = 1 → RX.
    - 1 → counter+1; if counter reaches max(`timeout_i`,1) → set `err_timeout_o` → DONE.
  - **RX**
    - Each tick shifts in `cmd_in_i` until 48 (short) or 136 (long) bits are received → CHECK.
  - **CHECK** (one PCLK, no tick required)
    - All types: transmission bit ≠ 0 or end bit ≠ 1 → `err_end_o`.
    - Type 01 only: index ≠ latched index → `err_index_o`.
    - Type 01 only: CRC7 over received bits 47:8 ≠ received bits 7:1 → `err_crc_o`.
    - Load `rsp_o`/`rsp_index_o` even on error → DONE.
  - **DONE**
    - `done_o`=1 for exactly one PCLK, `busy_o`=0 in that same cycle → IDLE.
- `cmd_start_i` outside IDLE (including DONE) is ignored; no queuing.
- Latched command inputs may change freely after acceptance.

## Timing
- Reset values:
  - `cmd_out_o`=1, `cmd_oe_o`=0, `busy_o`=0, `done_o`=0.
  - `rsp_o`=0, `rsp_index_o`=0, all error flags 0, state IDLE.
- Acceptance: `cmd_start_i` high in IDLE at edge N.
  - Edge N+1: `busy_o`=1, `cmd_oe_o`=1, `cmd_out_o`=1 (idle-high).
  - A tick coinciding with acceptance is not consumed.
- Each tick takes effect at the PCLK edge where `sdclk_tick_i`=1; outputs change one PCLK later.
- The end bit is held for one full tick period before release. `cmd_oe_o` and the WAIT sampling never overlap.
- Type 00 latency: 49 ticks after acceptance, plus 1 PCLK for the DONE pulse.
- Short-response latency: 49 + W + 48 ticks, plus 2 PCLK (CHECK, DONE), where W = ticks sampled high in WAIT.
- Flags, `rsp_o` and `rsp_index_o` are stable from the `done_o` cycle until the next acceptance.
- `PRESET_i` asserted in any state → next edge returns all outputs to reset values. No `done_o` is produced for the aborted command.

## Test plan
- **CMD0, arg 0, type 00, tick every 4 PCLK**
  - Serial frame = 0x400000000095.
  - `cmd_oe_o` high for exactly 49 ticks.
  - `done_o` pulses once; no errors.
- **CMD8, arg 0x000001AA, type 01**
  - Frame = 0x48000001AA87.
  - Model replies 0x08000001AA13 after 5 ticks.
  - Expect `rsp_o[31:0]`=0x000001AA, `rsp_index_o`=8, no errors.
- **Same CMD8 exchange with corrupted CRC byte (0x15)**
  - Expect `err_crc_o`=1, others 0.
  - Repeat with reply index 9 → `err_index_o`=1.
- **CMD17, arg 0, type 01, `timeout_i`=64, card silent**
  - Frame = 0x510000000055.
  - `err_timeout_o`=1 exactly 64 ticks after release.
  - `rsp_o`=0.
- **CMD2, type 10, model sends a 136-bit R2 with CID 0x1D414453443132332000000001ABCDEF**
  - `rsp_o[127:1]` matches card bits 127:1.
  - End bit forced to 0 → `err_end_o`=1.
- **Reset and ignored starts**
  - Assert `PRESET_i` mid-TX → next edge `cmd_oe_o`=0, `busy_o`=0, no `done_o`.
  - `cmd_start_i` pulsed while busy → ignored; exactly one `done_o` per accepted command.
